// File: rtl/guess_game_if.sv
// guess_game_if
//   Groups the player controls and display pins of the dice-guessing game.
//   master : the board side (drives sw/up, observes the display and score)
//   slave  : the game core (samples sw/up, drives am/out/over/score)
//   Signals:
//     sw    roll request, level
//     up    guess-advance request, level
//     am    digit enables, active-low one-hot
//     out   segments {a,b,c,d,e,f,g,dp}, active-low
//     over  game-over flag
//     score current score, binary 0..99
interface guess_game_if;
   logic       sw;
   logic       up;
   logic [3:0] am;
   logic [7:0] out;
   logic       over;
   logic [6:0] score;

   modport master (
      output sw,
      output up,
      input  am,
      input  out,
      input  over,
      input  score
   );

   modport slave (
      input  sw,
      input  up,
      output am,
      output out,
      output over,
      output score
   );
endinterface

// File: rtl/guess_game_core.sv
// guess_game_core
//   Dice-guessing game. A free-running LFSR supplies a die face (uniform by
//   rejection of out-of-range nibbles), which is compared with the player's
//   guess. A saturating score is kept; reaching zero ends the game until
//   reset. A 4-digit multiplexed active-low 7-segment display shows
//   face, guess and score (tens/ones).
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    guess_game_if.slave: sw/up in; am/out/over/score out
module guess_game_core #(
   parameter int         TICK_DIV    = 2**24,
   parameter int         SCAN_DIV    = 2**14,
   parameter int         FACES       = 6,
   parameter int         START_SCORE = 10,
   parameter int         WIN_PTS     = 6,
   parameter int         LOSS_PTS    = 1,
   parameter logic [7:0] SEED        = 8'hA5
) (
   input logic          clk,
   input logic          reset,
   guess_game_if.slave  bus
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [3:0] FACES_V = 4'(FACES);
   localparam logic [6:0] START_V = 7'(START_SCORE);
   localparam logic [6:0] LOSS_V  = 7'(LOSS_PTS);
   localparam logic [7:0] WIN_V   = 8'(WIN_PTS);

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      DRAW = 2'd1,
      OVER = 2'd2
   } state_t;

   // active-low segment code for one decimal digit
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'b00000011;
         4'd1:    s = 8'b10011111;
         4'd2:    s = 8'b00100101;
         4'd3:    s = 8'b00001101;
         4'd4:    s = 8'b10011001;
         4'd5:    s = 8'b01001001;
         4'd6:    s = 8'b01000001;
         4'd7:    s = 8'b00011111;
         4'd8:    s = 8'b00000001;
         4'd9:    s = 8'b00001001;
         default: s = 8'b11111111;
      endcase
      return s;
   endfunction

   // {tens, ones} of a 0..99 value by repeated subtraction of ten
   function automatic logic [7:0] to_bcd(input logic [6:0] val);
      logic [6:0] rem;
      logic [3:0] tens;
      rem  = val;
      tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem  = rem - 7'd10;
            tens = tens + 4'd1;
         end else begin
            rem  = rem;
         end
      end
      return {tens, rem[3:0]};
   endfunction

   state_t              state_r, state_s;
   logic [7:0]          lfsr_r;
   logic [TICK_W-1:0]   tick_cnt_r;
   logic [SCAN_W-1:0]   scan_cnt_r;
   logic                sw_q_r, up_q_r, blink_r;
   logic [3:0]          guess_r, guess_s;
   logic [3:0]          g_cap_r, g_cap_s;
   logic [3:0]          face_r, face_s;
   logic [6:0]          score_r, score_s;
   logic                over_r;
   logic [1:0]          dig_r;
   logic [3:0]          am_r, am_s;
   logic [7:0]          out_r, seg_s;
   logic [3:0]          dig_val_s;
   logic                blank_s;
   logic                tick_s, scan_step_s, sw_press_s, up_press_s;
   logic [3:0]          draw_v_s;
   logic [7:0]          sum_s;
   logic [7:0]          bcd_s;

   assign tick_s      = (tick_cnt_r == TICK_LAST);
   assign scan_step_s = (scan_cnt_r == SCAN_LAST);
   // a press is the first tick sample at 1 after a tick sample at 0
   assign sw_press_s  = tick_s & bus.sw & ~sw_q_r;
   assign up_press_s  = tick_s & bus.up & ~up_q_r;
   assign draw_v_s    = lfsr_r[3:0];
   // one spare bit so a large win cannot wrap before saturation
   assign sum_s       = {1'b0, score_r} + WIN_V;
   assign bcd_s       = to_bcd(score_r);

   // LFSR, tick divider, control sampling and blink phase
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r     <= SEED;
         tick_cnt_r <= {TICK_W{1'b0}};
         sw_q_r     <= 1'b0;
         up_q_r     <= 1'b0;
         blink_r    <= 1'b0;
      end else begin
         lfsr_r     <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
         tick_cnt_r <= tick_s ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
         if (tick_s) begin
            sw_q_r  <= bus.sw;
            up_q_r  <= bus.up;
            blink_r <= ~blink_r;
         end
      end
   end

   // game state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= PLAY;
         guess_r <= 4'd1;
         g_cap_r <= 4'd1;
         face_r  <= 4'd0;
         score_r <= START_V;
         over_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         guess_r <= guess_s;
         g_cap_r <= g_cap_s;
         face_r  <= face_s;
         score_r <= score_s;
         over_r  <= (state_s == OVER);
      end
   end

   // next game state: guess stepping, roll capture, rejection draw and scoring
   always_comb begin
      state_s = state_r;
      guess_s = guess_r;
      g_cap_s = g_cap_r;
      face_s  = face_r;
      score_s = score_r;
      case (state_r)
         PLAY: begin
            if (up_press_s) begin
               if (guess_r >= FACES_V) begin
                  guess_s = 4'd1;
               end else begin
                  guess_s = guess_r + 4'd1;
               end
            end else begin
               guess_s = guess_r;
            end
            // captures the guess before any same-tick increment
            if (sw_press_s) begin
               g_cap_s = guess_r;
               state_s = DRAW;
            end else begin
               state_s = PLAY;
            end
         end
         DRAW: begin
            if ((draw_v_s != 4'd0) && (draw_v_s <= FACES_V)) begin
               face_s = draw_v_s;
               if (draw_v_s == g_cap_r) begin
                  if (sum_s > 8'd99) begin
                     score_s = 7'd99;
                  end else begin
                     score_s = sum_s[6:0];
                  end
                  state_s = PLAY;
               end else if (score_r > LOSS_V) begin
                  score_s = score_r - LOSS_V;
                  state_s = PLAY;
               end else begin
                  score_s = 7'd0;
                  state_s = OVER;
               end
            end else begin
               state_s = DRAW;
            end
         end
         OVER: begin
            state_s = OVER;
         end
         default: begin
            state_s = PLAY;
         end
      endcase
   end

   // digit selection and segment pattern for the digit about to be scanned
   always_comb begin
      am_s      = 4'b1111;
      dig_val_s = 4'd0;
      blank_s   = 1'b0;
      case (dig_r)
         2'd0: begin
            am_s      = 4'b1110;
            dig_val_s = face_r;
            blank_s   = (face_r == 4'd0);
         end
         2'd1: begin
            am_s      = 4'b1101;
            dig_val_s = guess_r;
         end
         2'd2: begin
            am_s      = 4'b1011;
            dig_val_s = bcd_s[3:0];
         end
         2'd3: begin
            am_s      = 4'b0111;
            dig_val_s = bcd_s[7:4];
         end
         default: begin
            am_s      = 4'b1111;
            dig_val_s = 4'd0;
         end
      endcase
      if (blank_s || (blink_r && (state_r == OVER))) begin
         seg_s = 8'b11111111;
      end else begin
         seg_s = seg7(dig_val_s);
      end
   end

   // display scan: am and out change together, one digit per SCAN_DIV clks
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_r <= {SCAN_W{1'b0}};
         dig_r      <= 2'd0;
         am_r       <= 4'b1111;
         out_r      <= 8'b11111111;
      end else if (scan_step_s) begin
         scan_cnt_r <= {SCAN_W{1'b0}};
         dig_r      <= dig_r + 2'd1;
         am_r       <= am_s;
         out_r      <= seg_s;
      end else begin
         scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
   end

   assign bus.am    = am_r;
   assign bus.out   = out_r;
   assign bus.over  = over_r;
   assign bus.score = score_r;

endmodule

// File: tb/tb_guess_game_core.sv
// tb_guess_game_core
//   Three game cores (FACES 6/1/9) on a shared clock and reset. Stimulus
//   pushes expected display digits into a scoreboard; a monitor compares each
//   one when that digit is next scanned. Roll outcomes come from an LFSR and
//   tick model kept alongside the DUTs.
module tb_guess_game_core;
   localparam int TD   = 4;
   localparam int SD   = 2;
   localparam int WIN  = 6;
   localparam int LOSS = 1;

   typedef struct {
      int         dut;
      int         dig;
      logic [7:0] seg;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       sw_v [3];
   logic       up_v [3];
   logic [3:0] am_v [3];
   logic [7:0] out_v [3];
   logic       over_v [3];
   logic [6:0] score_v [3];

   int   total = 0;
   int   bad   = 0;
   exp_t sbq[$];
   int   exp_score [3];
   bit   exp_over [3];

   logic [7:0] lfsr_m;
   int         tcnt_m;

   always #5 clk = ~clk;

   guess_game_if if0();
   guess_game_if if1();
   guess_game_if if2();

   assign if0.sw = sw_v[0];
   assign if0.up = up_v[0];
   assign if1.sw = sw_v[1];
   assign if1.up = up_v[1];
   assign if2.sw = sw_v[2];
   assign if2.up = up_v[2];
   assign am_v[0] = if0.am;    assign out_v[0] = if0.out;
   assign am_v[1] = if1.am;    assign out_v[1] = if1.out;
   assign am_v[2] = if2.am;    assign out_v[2] = if2.out;
   assign over_v[0] = if0.over; assign score_v[0] = if0.score;
   assign over_v[1] = if1.over; assign score_v[1] = if1.score;
   assign over_v[2] = if2.over; assign score_v[2] = if2.score;

   guess_game_core #(.TICK_DIV(TD), .SCAN_DIV(SD), .FACES(6), .START_SCORE(10),
      .WIN_PTS(WIN), .LOSS_PTS(LOSS), .SEED(8'hA5)) dut6 (.clk(clk), .reset(reset), .bus(if0));
   guess_game_core #(.TICK_DIV(TD), .SCAN_DIV(SD), .FACES(1), .START_SCORE(90),
      .WIN_PTS(WIN), .LOSS_PTS(LOSS), .SEED(8'hA5)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   guess_game_core #(.TICK_DIV(TD), .SCAN_DIV(SD), .FACES(9), .START_SCORE(1),
      .WIN_PTS(WIN), .LOSS_PTS(LOSS), .SEED(8'hA5)) dut9 (.clk(clk), .reset(reset), .bus(if2));

   function automatic logic [7:0] nxt(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'b00000011;
         1: return 8'b10011111;
         2: return 8'b00100101;
         3: return 8'b00001101;
         4: return 8'b10011001;
         5: return 8'b01001001;
         6: return 8'b01000001;
         7: return 8'b00011111;
         8: return 8'b00000001;
         9: return 8'b00001001;
         default: return 8'b11111111;
      endcase
   endfunction

   function automatic logic [3:0] am_for(input int dig);
      case (dig)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         3: return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // reference LFSR and tick counter
   always @(posedge clk) begin
      if (reset) begin
         lfsr_m <= 8'hA5;
         tcnt_m <= 0;
      end else begin
         lfsr_m <= nxt(lfsr_m);
         tcnt_m <= (tcnt_m == TD - 1) ? 0 : tcnt_m + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic push(input int d, input int dig, input logic [7:0] seg);
      exp_t e;
      e.dut = d;
      e.dig = dig;
      e.seg = seg;
      sbq.push_back(e);
   endtask

   task automatic push_score(input int d, input int s);
      push(d, 2, seg_of(s % 10));
      push(d, 3, seg_of(s / 10));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", sbq.size(), 0);
      sbq.delete();
   endtask

   // returns at the negedge just before a tick edge
   task automatic wait_tick();
      @(negedge clk);
      while (tcnt_m != TD - 1) @(negedge clk);
   endtask

   task automatic press(input int d, input bit do_sw, input bit do_up);
      wait_tick();
      if (do_sw) sw_v[d] = 1'b1;
      if (do_up) up_v[d] = 1'b1;
      @(negedge clk);
      sw_v[d] = 1'b0;
      up_v[d] = 1'b0;
      wait_tick();
      @(negedge clk);
   endtask

   task automatic roll(input int d, input int faces, input int gcap, input bit with_up, output int v);
      logic [7:0] l;
      int k, old, nw;
      bit ov;
      wait_tick();
      sw_v[d] = 1'b1;
      if (with_up) up_v[d] = 1'b1;
      @(negedge clk);
      sw_v[d] = 1'b0;
      up_v[d] = 1'b0;
      l = lfsr_m;
      k = 0;
      while (!((l[3:0] >= 4'd1) && (int'(l[3:0]) <= faces)) && k < 300) begin
         l = nxt(l);
         k++;
      end
      v   = int'(l[3:0]);
      old = exp_score[d];
      ov  = 1'b0;
      if (v == gcap) begin
         nw = (old + WIN > 99) ? 99 : old + WIN;
      end else if (old > LOSS) begin
         nw = old - LOSS;
      end else begin
         nw = 0;
         ov = 1'b1;
      end
      repeat (k) @(negedge clk);
      chk($sformatf("dut%0d score_before_face", d), int'(score_v[d]), old);
      @(negedge clk);
      chk($sformatf("dut%0d score_at_face", d), int'(score_v[d]), nw);
      chk($sformatf("dut%0d over_at_face", d), int'(over_v[d]), int'(ov));
      exp_score[d] = nw;
      exp_over[d]  = ov;
      wait_tick();
      @(negedge clk);
   endtask

   // scoreboard monitor: compares on the first cycle a digit is freshly scanned
   initial begin
      logic [3:0] prev [3];
      exp_t       e;
      prev[0] = 4'hF;
      prev[1] = 4'hF;
      prev[2] = 4'hF;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq[0];
            if ((am_v[e.dut] != prev[e.dut]) && (am_v[e.dut] == am_for(e.dig))) begin
               chk($sformatf("dut%0d digit%0d", e.dut, e.dig), int'(out_v[e.dut]), int'(e.seg));
               void'(sbq.pop_front());
            end
         end
         for (int i = 0; i < 3; i++) prev[i] = am_v[i];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, n, last_face, nb, nv, dig;
      logic [7:0] want;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sw_v[i] = 1'b0;
         up_v[i] = 1'b0;
         exp_over[i] = 1'b0;
      end
      exp_score[0] = 10;
      exp_score[1] = 90;
      exp_score[2] = 1;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_am", int'(am_v[0]), 'hF);
      chk("rst_out", int'(out_v[0]), 'hFF);
      chk("rst_over", int'(over_v[0]), 0);
      chk("rst_score6", int'(score_v[0]), 10);
      chk("rst_score1", int'(score_v[1]), 90);
      chk("rst_score9", int'(score_v[2]), 1);
      reset = 1'b0;
      @(negedge clk);
      chk("am_before_scan", int'(am_v[0]), 'hF);
      @(negedge clk);
      chk("first_digit_am", int'(am_v[0]), 'hE);
      chk("first_digit_out", int'(out_v[0]), 'hFF);

      // test 1: idle display
      repeat (40) @(negedge clk);
      chk("idle_score", int'(score_v[0]), 10);
      chk("idle_over", int'(over_v[0]), 0);
      push(0, 3, 8'b10011111);
      push(0, 2, 8'b00000011);
      push(0, 1, 8'b10011111);
      push(0, 0, 8'b11111111);
      drain();

      // test 2: guess stepping and hold
      repeat (3) press(0, 1'b0, 1'b1);
      push(0, 1, 8'b10011001);
      drain();
      repeat (3) press(0, 1'b0, 1'b1);
      push(0, 1, 8'b10011111);
      drain();
      wait_tick();
      up_v[0] = 1'b1;
      repeat (20 * TD) @(negedge clk);
      up_v[0] = 1'b0;
      wait_tick();
      @(negedge clk);
      push(0, 1, 8'b00100101);
      drain();

      // test 3: always-match die, saturation at 99
      roll(1, 1, 1, 1'b0, v);
      chk("dut1_roll1", int'(score_v[1]), 96);
      push(1, 0, 8'b10011111);
      push(1, 2, 8'b01000001);
      push(1, 3, 8'b00001001);
      drain();
      roll(1, 1, 1, 1'b0, v);
      chk("dut1_roll2", int'(score_v[1]), 99);
      roll(1, 1, 1, 1'b0, v);
      chk("dut1_roll3", int'(score_v[1]), 99);
      push(1, 2, 8'b00001001);
      push(1, 3, 8'b00001001);
      drain();

      // test 4: play to game over
      n = 0;
      last_face = 0;
      while (!exp_over[2] && n < 100) begin
         roll(2, 9, 1, 1'b0, v);
         last_face = v;
         if (!exp_over[2]) begin
            push(2, 0, seg_of(v));
            push_score(2, exp_score[2]);
            drain();
         end
         n++;
      end
      chk("dut9_over", int'(over_v[2]), 1);
      press(2, 1'b1, 1'b0);
      press(2, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      chk("dut9_over_score", int'(score_v[2]), 0);
      chk("dut9_over_hold", int'(over_v[2]), 1);
      nb = 0;
      nv = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (am_v[2] != 4'b1111) begin
            if (out_v[2] == 8'hFF) begin
               nb++;
            end else begin
               nv++;
               case (am_v[2])
                  4'b1110: dig = 0;
                  4'b1101: dig = 1;
                  4'b1011: dig = 2;
                  default: dig = 3;
               endcase
               case (dig)
                  0:       want = seg_of(last_face);
                  1:       want = seg_of(1);
                  default: want = seg_of(0);
               endcase
               chk($sformatf("dut9_over_digit%0d", dig), int'(out_v[2]), int'(want));
            end
         end
      end
      chk("dut9_blink", int'((nb > 0) && (nv > 0)), 1);

      // test 5: same-tick up and sw with guess 3
      press(0, 1'b0, 1'b1);
      push(0, 1, 8'b00001101);
      drain();
      roll(0, 6, 3, 1'b1, v);
      push(0, 0, seg_of(v));
      push(0, 1, 8'b10011001);
      push_score(0, exp_score[0]);
      drain();

      // test 6: reset while drawing
      wait_tick();
      sw_v[0] = 1'b1;
      @(negedge clk);
      sw_v[0] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_draw_rst_score", int'(score_v[0]), 10);
      chk("mid_draw_rst_am", int'(am_v[0]), 'hF);
      chk("mid_draw_rst_over9", int'(over_v[2]), 0);
      reset = 1'b0;
      exp_score[0] = 10;
      repeat (30) @(negedge clk);
      chk("post_rst_score", int'(score_v[0]), 10);
      press(0, 1'b0, 1'b1);
      push(0, 1, 8'b00100101);
      push(0, 0, 8'b11111111);
      drain();
      chk("post_rst_score_final", int'(score_v[0]), 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
